alu_opfetch: RTL and testbench
==============================

# alu_opfetch

Operand-fetch stage directly upstream of the ALU. Holds the architectural register file and accepts decoded instruction fields. It reads both source operands and presents them registered to the ALU's `rs1`/`rs2`/`op` inputs one cycle after issue. The ALU result returns on a writeback port, which clears a per-register busy scoreboard, so read-after-write and write-after-write hazards stall issue instead of delivering stale operands.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `AW`, 5: register address width; `2**AW` registers.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage can issue this cycle (combinational).
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr`  in  AW  source and destination register numbers.
- `in_op`  in  4  ALU opcode, passed through unchanged.
- `out_valid`  out  1  operands valid for the ALU this cycle.
- `out_rs1`, `out_rs2`  out  XLEN  operand values.
- `out_op`  out  4  registered opcode.
- `out_rd_addr`  out  AW  registered destination.
- `wb_valid`  in  1  writeback strobe.
- `wb_addr`  in  AW  writeback register.
- `wb_data`  in  XLEN  writeback value.

## Operation
- **Issue:** an instruction issues when `in_valid && in_ready`. There is no backpressure from the ALU; it always accepts.
- **Busy scoreboard:** `busy[r]` is set on issue for `in_rd_addr` when it is nonzero, and cleared on `wb_valid` at `wb_addr`.
- **Register x0:** reads return 0, writes are ignored, and it is never busy.
- **in_ready:** deasserted if `rs1`, `rs2` or `rd` is busy (x0 excluded). A register being cleared by writeback in the same cycle counts as busy unless `OPFETCH_BYPASS_EN` is defined.
- **Simultaneous writeback clear and issue set on the same register:** the set wins, leaving `busy` = 1.
- **Writeback register-file write:** on the rising edge, for any nonzero `wb_addr`, independent of issue.
- **Operand read:** reads the register-file contents before the same-edge write. When `OPFETCH_BYPASS_EN` is defined, a source matching `wb_addr` (nonzero) takes `wb_data` instead.
- **Arithmetic:** none. Operands are forwarded bit-exact.
- **Reset (may assert mid-operation):**
  - all registers cleared to 0;
  - all `busy` bits cleared;
  - `out_valid` = 0;
  - `out_rs1`, `out_rs2`, `out_op`, `out_rd_addr` = 0;
  - any in-flight writeback is discarded.

## Timing
- **Issue latency:** issue at edge N gives `out_valid` = 1 and valid operand, opcode and destination outputs during cycle N+1.
- **out_valid:** a one-cycle pulse per issue, asserted every cycle under back-to-back issue. When no issue occurs, `out_valid` = 0 and the operand, opcode and destination outputs hold their last values.
- **Writeback:** visible to reads issued at the next edge; visible to the same edge only with bypass.
- **Throughput:** one instruction per cycle absent hazards.

## Configuration
- **`OPFETCH_BYPASS_EN` defined:** writeback-to-read forwarding. A consumer of a writeback issues in the writeback cycle, and the RAW stall ends in the same cycle the writeback arrives.
- **`OPFETCH_BYPASS_EN` not defined:** no forwarding. The consumer issues one cycle after the writeback, which saves the forwarding muxes.

## Structure
- **Shared package:**
  - `XLEN` and `AW` defaults;
  - 4-bit ALU opcode constants (add 4'b0000, sub 4'b0001, 4'b0110, 4'b0111 and the remaining encodings), common with the ALU.
- **Sub-module `regfile`:**
  - `2**AW` x `XLEN` storage with two asynchronous read ports and one synchronous write port;
  - x0 hardwired to zero;
  - async active-low reset to zero.
- Scoreboard, issue logic and output registers live in `alu_opfetch`.

## Test plan
- **Basic issue:** write x3=71 and x4=82 via writeback; issue `op`=4'b0000, rs1=3, rs2=4, rd=5 → next cycle `out_valid`=1, `out_rs1`=71, `out_rs2`=82, `out_op`=0000, `out_rd_addr`=5, `busy[5]`=1.
- **RAW stall:** issue rd=5, then rs1=5, rs2=0 → `in_ready`=0 until `wb_valid`, addr 5, data 153.
  - With bypass: issues in the writeback cycle, `out_rs1`=153.
  - Without bypass: issues one cycle later, `out_rs1`=153.
- **WAW stall:** issue rd=6 twice back-to-back → second stalls until writeback to x6 → `busy[6]` remains 1 after the second issue.
- **x0:** writeback to x0 with data 99, then read rs1=0 → `out_rs1`=0; issue rd=0 repeatedly → never stalls.
- **Independent throughput:** issue 16=x1, 3=x2 and 16=x7, 8=x8 pairs on consecutive cycles with no dependencies → `out_valid` high every cycle, correct operands each cycle.
- **Reset mid-operation:** assert `reset`=0 with `busy[5]` set and `out_valid`=1 → asynchronously `out_valid`=0 and all outputs 0; after release `in_ready`=1 and any register reads 0.

Source files
------------

// File: rtl/alu_opfetch_pkg.sv
// Shared definitions for the operand-fetch stage and the ALU behind it:
// default widths and the 4-bit ALU opcode encoding.
package alu_opfetch_pkg;

   localparam int XLEN_DEF = 32;
   localparam int AW_DEF   = 5;
   localparam int OPW      = 4;

   // Encoding shared with the ALU; the fetch stage only carries it through.
   typedef enum logic [OPW-1:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_SLL  = 4'b0010,
      OP_SLT  = 4'b0011,
      OP_SLTU = 4'b0100,
      OP_XOR  = 4'b0101,
      OP_OR   = 4'b0110,
      OP_AND  = 4'b0111,
      OP_SRL  = 4'b1000,
      OP_SRA  = 4'b1001,
      OP_MUL  = 4'b1010,
      OP_MULH = 4'b1011,
      OP_LUI  = 4'b1100,
      OP_PASS = 4'b1101,
      OP_EQ   = 4'b1110,
      OP_NE   = 4'b1111
   } alu_op_e;

endpackage

// File: rtl/alu_opfetch_regfile.sv
// Architectural register file: 2**AW x XLEN, two asynchronous read ports,
// one synchronous write port, x0 hardwired to zero.
module alu_opfetch_regfile
   import alu_opfetch_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int AW   = AW_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rd_addr1,
   output logic [XLEN-1:0] rd_data1,
   input  logic [AW-1:0]   rd_addr2,
   output logic [XLEN-1:0] rd_data2,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data
);

   localparam int NREG = 2**AW;

   logic [XLEN-1:0] mem [NREG];

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data1 = (rd_addr1 == '0) ? '0 : mem[rd_addr1];
   assign rd_data2 = (rd_addr2 == '0) ? '0 : mem[rd_addr2];

endmodule

// File: rtl/alu_opfetch.sv
// Operand-fetch stage: register file read, busy scoreboard for RAW/WAW stalls,
// registered operands to the ALU. Define OPFETCH_BYPASS_EN for writeback forwarding.
module alu_opfetch
   import alu_opfetch_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int AW   = AW_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rs1_addr,
   input  logic [AW-1:0]   in_rs2_addr,
   input  logic [AW-1:0]   in_rd_addr,
   input  logic [OPW-1:0]  in_op,
   output logic            out_valid,
   output logic [XLEN-1:0] out_rs1,
   output logic [XLEN-1:0] out_rs2,
   output logic [OPW-1:0]  out_op,
   output logic [AW-1:0]   out_rd_addr,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data
);

   localparam int NREG = 2**AW;

   logic [NREG-1:0] busy_reg;
   logic [NREG-1:0] busy_next;
   logic [NREG-1:0] clear_mask;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] busy_view;
   logic [XLEN-1:0] rf_rd1;
   logic [XLEN-1:0] rf_rd2;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            wb_hit;
   logic            issue;

   assign wb_hit = wb_valid && (wb_addr != '0);

   alu_opfetch_regfile #(
      .XLEN (XLEN),
      .AW   (AW)
   ) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .rd_addr1 (in_rs1_addr),
      .rd_data1 (rf_rd1),
      .rd_addr2 (in_rs2_addr),
      .rd_data2 (rf_rd2),
      .wr_en    (wb_hit),
      .wr_addr  (wb_addr),
      .wr_data  (wb_data)
   );

   // x0 never gets a set bit, so it can never stall issue.
   for (genvar gi = 0; gi < NREG; gi++) begin : g_mask
      assign clear_mask[gi] = wb_hit && (wb_addr == AW'(gi));
      if (gi == 0) begin : g_x0
         assign set_mask[gi] = 1'b0;
      end else begin : g_xn
         assign set_mask[gi] = issue && (in_rd_addr == AW'(gi));
      end
   end

   // A same-edge set overrides a same-edge clear (WAW re-issue keeps busy).
   assign busy_next = (busy_reg & ~clear_mask) | set_mask;

`ifdef OPFETCH_BYPASS_EN
   assign busy_view = busy_reg & ~clear_mask;
   assign rs1_val   = (wb_hit && (wb_addr == in_rs1_addr)) ? wb_data : rf_rd1;
   assign rs2_val   = (wb_hit && (wb_addr == in_rs2_addr)) ? wb_data : rf_rd2;
`else
   assign busy_view = busy_reg;
   assign rs1_val   = rf_rd1;
   assign rs2_val   = rf_rd2;
`endif

   assign in_ready = !(busy_view[in_rs1_addr] || busy_view[in_rs2_addr] ||
                       busy_view[in_rd_addr]);
   assign issue    = in_valid && in_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   // Operand/opcode/destination hold their last values between issues.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid   <= 1'b0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_op      <= '0;
         out_rd_addr <= '0;
      end else begin
         out_valid <= issue;
         if (issue) begin
            out_rs1     <= rs1_val;
            out_rs2     <= rs2_val;
            out_op      <= in_op;
            out_rd_addr <= in_rd_addr;
         end
      end
   end

endmodule

// File: tb/tb_alu_opfetch.sv
// Directed bench for alu_opfetch: array-level reference model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_alu_opfetch;
   import alu_opfetch_pkg::*;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [AW-1:0]   in_rs1_addr;
   logic [AW-1:0]   in_rs2_addr;
   logic [AW-1:0]   in_rd_addr;
   logic [3:0]      in_op;
   logic            out_valid;
   logic [XLEN-1:0] out_rs1;
   logic [XLEN-1:0] out_rs2;
   logic [3:0]      out_op;
   logic [AW-1:0]   out_rd_addr;
   logic            wb_valid;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;

   int errors = 0;
   int checks = 0;
   bit armed  = 0;

   alu_opfetch #(.XLEN(XLEN), .AW(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rs1_addr (in_rs1_addr),
      .in_rs2_addr (in_rs2_addr),
      .in_rd_addr  (in_rd_addr),
      .in_op       (in_op),
      .out_valid   (out_valid),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_op      (out_op),
      .out_rd_addr (out_rd_addr),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: register contents and busy flags as plain arrays.
   logic [XLEN-1:0] m_regs [32];
   bit              m_busy [32];
   logic            e_valid;
   logic [XLEN-1:0] e_rs1;
   logic [XLEN-1:0] e_rs2;
   logic [3:0]      e_op;
   logic [AW-1:0]   e_rd;

   function automatic bit m_free(input logic [AW-1:0] a);
      if (!m_busy[a]) return 1'b1;
`ifdef OPFETCH_BYPASS_EN
      if (wb_valid && (wb_addr == a) && (a != 0)) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic bit m_ready_now();
      return m_free(in_rs1_addr) && m_free(in_rs2_addr) && m_free(in_rd_addr);
   endfunction

   function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
      if (a == 0) return '0;
`ifdef OPFETCH_BYPASS_EN
      if (wb_valid && (wb_addr == a)) return wb_data;
`endif
      return m_regs[a];
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] <= '0;
            m_busy[i] <= 1'b0;
         end
         e_valid <= 1'b0;
         e_rs1   <= '0;
         e_rs2   <= '0;
         e_op    <= '0;
         e_rd    <= '0;
      end else begin
         e_valid <= in_valid && m_ready_now();
         if (in_valid && m_ready_now()) begin
            e_rs1 <= m_read(in_rs1_addr);
            e_rs2 <= m_read(in_rs2_addr);
            e_op  <= in_op;
            e_rd  <= in_rd_addr;
         end
         if (wb_valid && (wb_addr != 0)) begin
            m_regs[wb_addr] <= wb_data;
            m_busy[wb_addr] <= 1'b0;
         end
         if (in_valid && m_ready_now() && (in_rd_addr != 0)) begin
            m_busy[in_rd_addr] <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   initial begin
      wait (armed);
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("model_in_ready", 32'(in_ready), 32'(m_ready_now()));
            chk("model_out_valid", 32'(out_valid), 32'(e_valid));
            chk("model_out_rs1", out_rs1, e_rs1);
            chk("model_out_rs2", out_rs2, e_rs2);
            chk("model_out_op", 32'(out_op), 32'(e_op));
            chk("model_out_rd", 32'(out_rd_addr), 32'(e_rd));
            if (out_valid)
               $display("txn op=%0d rd=x%0d rs1=%0d rs2=%0d", out_op, out_rd_addr, out_rs1, out_rs2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ins(input logic [3:0] op, input logic [AW-1:0] rs1,
                          input logic [AW-1:0] rs2, input logic [AW-1:0] rd);
      in_valid    = 1'b1;
      in_op       = op;
      in_rs1_addr = rs1;
      in_rs2_addr = rs2;
      in_rd_addr  = rd;
   endtask

   task automatic set_wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      wb_valid = 1'b1;
      wb_addr  = a;
      wb_data  = d;
   endtask

   // Holds the current instruction until it issues (bounded), then drops in_valid.
   task automatic issue_wait(input int max_cycles);
      bit ok = 0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
         tick();
         wb_valid = 1'b0;
      end
      if (!ok) chk("issue_wait", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      wb_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_op = '0; in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      armed = 1;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_rs1", out_rs1, 32'd0);

      // Basic issue
      tick(); set_wb(3, 71);
      tick(); set_wb(4, 82);
      tick(); wb_valid = 1'b0; set_ins(OP_ADD, 3, 4, 5);
      tick(); in_valid = 1'b0; in_rs1_addr = 5; in_rs2_addr = 0; in_rd_addr = 0;
      @(negedge clk);
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_rs1", out_rs1, 32'd71);
      chk("basic_rs2", out_rs2, 32'd82);
      chk("basic_op", 32'(out_op), 32'd0);
      chk("basic_rd", 32'(out_rd_addr), 32'd5);
      chk("basic_busy5", 32'(in_ready), 32'd0);

      // RAW stall on x5
      tick(); set_ins(OP_SUB, 5, 0, 9);
      @(negedge clk); chk("raw_stall0", 32'(in_ready), 32'd0);
      tick();
      @(negedge clk); chk("raw_stall1", 32'(in_ready), 32'd0);
      tick(); set_wb(5, 153);
      @(negedge clk);
`ifdef OPFETCH_BYPASS_EN
      chk("raw_wb_cycle_ready", 32'(in_ready), 32'd1);
      tick(); wb_valid = 1'b0; in_valid = 1'b0;
`else
      chk("raw_wb_cycle_ready", 32'(in_ready), 32'd0);
      tick(); wb_valid = 1'b0;
      @(negedge clk); chk("raw_after_wb_ready", 32'(in_ready), 32'd1);
      tick(); in_valid = 1'b0;
`endif
      @(negedge clk);
      chk("raw_valid", 32'(out_valid), 32'd1);
      chk("raw_rs1", out_rs1, 32'd153);
      chk("raw_rd", 32'(out_rd_addr), 32'd9);

      // WAW stall on x6 (also retire x9)
      tick(); set_wb(9, 5); set_ins(OP_OR, 0, 0, 6);
      @(negedge clk); chk("waw_first_ready", 32'(in_ready), 32'd1);
      tick(); wb_valid = 1'b0;
      @(negedge clk); chk("waw_stall0", 32'(in_ready), 32'd0);
      tick();
      @(negedge clk); chk("waw_stall1", 32'(in_ready), 32'd0);
      tick(); set_wb(6, 44);
      issue_wait(4);
      in_rs1_addr = 6; in_rd_addr = 0;
      @(negedge clk);
      chk("waw_second_valid", 32'(out_valid), 32'd1);
      chk("waw_second_rd", 32'(out_rd_addr), 32'd6);
      chk("waw_busy6", 32'(in_ready), 32'd0);
      tick(); set_wb(6, 44);
      tick(); wb_valid = 1'b0;

      // x0: writes ignored, never busy
      set_wb(0, 99);
      tick(); wb_valid = 1'b0; set_ins(OP_AND, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); chk("x0_ready", 32'(in_ready), 32'd1);
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("x0_valid", 32'(out_valid), 32'd1);
      chk("x0_rs1", out_rs1, 32'd0);

      // Independent back-to-back issue
      tick(); set_wb(1, 16);
      tick(); set_wb(2, 3);
      tick(); set_wb(7, 16);
      tick(); set_wb(8, 8);
      tick(); wb_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) set_ins(4'(k), 1, 2, 5'(12 + k));
         else            set_ins(4'(k), 7, 8, 5'(12 + k));
         tick();
         chk("tp_valid", 32'(out_valid), 32'd1);
         chk("tp_rs1", out_rs1, 32'd16);
         chk("tp_rs2", out_rs2, (k % 2 == 0) ? 32'd3 : 32'd8);
         chk("tp_rd", 32'(out_rd_addr), 32'(12 + k));
      end
      in_valid = 1'b0;

      // Reset mid-operation
      tick(); set_ins(OP_ADD, 1, 2, 5);
      tick(); in_valid = 1'b0;
      chk("mid_pre_valid", 32'(out_valid), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_rs1", out_rs1, 32'd0);
      chk("mid_rst_rs2", out_rs2, 32'd0);
      chk("mid_rst_op", 32'(out_op), 32'd0);
      chk("mid_rst_rd", 32'(out_rd_addr), 32'd0);
      tick(); reset = 1'b1; in_rs1_addr = 5; in_rs2_addr = 1; in_rd_addr = 5;
      @(negedge clk); chk("post_rst_ready", 32'(in_ready), 32'd1);
      tick(); set_ins(OP_ADD, 1, 2, 5);
      tick(); in_valid = 1'b0;
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_rs1", out_rs1, 32'd0);
      chk("post_rst_rs2", out_rs2, 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
